// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Row-edge input stage for a systolic MAC array. Each accepted vector is
// split into lanes, and lane i is delayed by i extra cycles so the array
// sees a diagonal wavefront. Bubbles enter as zero words with valid low.
// After the last vector of a tile, the feeder stops accepting until the
// skew chains have drained, then pulses done for one cycle.
//
// Handshake: a vector transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on the FSM state, so there
// is no combinational path from in_valid to in_ready. in_data and in_last
// are ignored on any cycle without a transfer.
module systolic_skew_feeder #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_LANES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [NUM_LANES*WORD_SIZE-1:0] in_data,
    output logic [NUM_LANES*WORD_SIZE-1:0] lane_out,
    output logic [NUM_LANES-1:0]           lane_valid,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     dbg_state
);

    // Flush counter must hold NUM_LANES-1; keep at least one bit.
    localparam int CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_done;
    logic          w_done_next;
    logic          w_accept;

    assign in_ready  = (r_state != ST_FLUSH);
    assign w_accept  = in_valid & in_ready;
    assign done      = r_done;
    assign dbg_state = r_state;
    assign busy      = (r_state != ST_IDLE) | (|lane_valid);

    // Skew chains: lane g holds g+1 stages and shifts every clock.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [WORD_SIZE-1:0] r_d [0:g];
        logic                 r_v [0:g];

        // Stage 0 captures the lane word on a transfer, otherwise a zero bubble.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= g; k++) begin
                    r_d[k] <= '0;
                    r_v[k] <= 1'b0;
                end
            end else begin
                r_d[0] <= w_accept ? in_data[g*WORD_SIZE +: WORD_SIZE] : '0;
                r_v[0] <= w_accept;
                for (int k = 1; k <= g; k++) begin
                    r_d[k] <= r_d[k-1];
                    r_v[k] <= r_v[k-1];
                end
            end
        end

        assign lane_out[g*WORD_SIZE +: WORD_SIZE] = r_d[g];
        assign lane_valid[g]                      = r_v[g];
    end

    // State, flush counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic: the last vector starts a flush that lasts exactly
    // as long as the deepest skew chain, so the drain finishes as done rises.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE, ST_STREAM: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_state_next = ST_FLUSH;
                        w_cnt_next   = FLUSH_LOAD;
                    end else begin
                        w_state_next = ST_STREAM;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with NUM_LANES=4, WORD_SIZE=8.
module tb_systolic_skew_feeder;

    localparam int W = 8;
    localparam int N = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [N*W-1:0] in_data;
    logic [N*W-1:0] lane_out;
    logic [N-1:0]   lane_valid;
    logic           busy;
    logic           done;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_skew_feeder #(.WORD_SIZE(W), .NUM_LANES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_data    (in_data),
        .lane_out   (lane_out),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic [N*W-1:0] d);
        in_valid = v;
        in_last  = l;
        in_data  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output of the current cycle.
    task automatic chk_cycle(input string tag, input logic [31:0] e_out, input logic [3:0] e_val,
                             input logic e_rdy, input logic e_done, input logic e_busy,
                             input logic [1:0] e_st);
        chk({tag, ".lane_out"},   lane_out,          e_out);
        chk({tag, ".lane_valid"}, 32'(lane_valid),   32'(e_val));
        chk({tag, ".in_ready"},   32'(in_ready),     32'(e_rdy));
        chk({tag, ".done"},       32'(done),         32'(e_done));
        chk({tag, ".busy"},       32'(busy),         32'(e_busy));
        chk({tag, ".state"},      32'(dbg_state),    32'(e_st));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Three back-to-back vectors, the third marked last.
    task automatic run_abc(input string pfx);
        drive(1'b1, 1'b0, 32'hA3A2A1A0);
        chk_cycle({pfx, ".c0"}, 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
        tick();
        drive(1'b1, 1'b0, 32'hB3B2B1B0);
        chk_cycle({pfx, ".c1"}, 32'h000000A0, 4'b0001, 1, 0, 1, S_STREAM);
        tick();
        drive(1'b1, 1'b1, 32'hC3C2C1C0);
        chk_cycle({pfx, ".c2"}, 32'h0000A1B0, 4'b0011, 1, 0, 1, S_STREAM);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_cycle({pfx, ".c3"}, 32'h00A2B1C0, 4'b0111, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle({pfx, ".c4"}, 32'hA3B2C100, 4'b1110, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle({pfx, ".c5"}, 32'hB3C20000, 4'b1100, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle({pfx, ".c6"}, 32'hC3000000, 4'b1000, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle({pfx, ".c7"}, 32'h0, 4'b0000, 1, 1, 0, S_IDLE);
        tick();
        chk_cycle({pfx, ".c8"}, 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, '0);

        // Reset, then idle with a stray in_last that must be ignored.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'hFFFFFFFF);
            chk_cycle($sformatf("idle.c%0d", i), 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
            tick();
        end

        // Single-vector tile: IDLE goes straight to FLUSH.
        drive(1'b1, 1'b1, 32'h04030201);
        chk_cycle("single.c0", 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_cycle("single.c1", 32'h00000001, 4'b0001, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("single.c2", 32'h00000200, 4'b0010, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("single.c3", 32'h00030000, 4'b0100, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("single.c4", 32'h04000000, 4'b1000, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("single.c5", 32'h0, 4'b0000, 1, 1, 0, S_IDLE);
        tick();
        chk_cycle("single.c6", 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
        tick();

        // Back-to-back stream of three.
        run_abc("abc");
        tick();

        // Bubble mid-tile: garbage data with valid low must enter as zero.
        drive(1'b1, 1'b0, 32'hA3A2A1A0);
        chk_cycle("bub.c0", 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
        tick();
        drive(1'b0, 1'b1, 32'hDEADBEEF);
        chk_cycle("bub.c1", 32'h000000A0, 4'b0001, 1, 0, 1, S_STREAM);
        tick();
        drive(1'b1, 1'b1, 32'hB3B2B1B0);
        chk_cycle("bub.c2", 32'h0000A100, 4'b0010, 1, 0, 1, S_STREAM);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_cycle("bub.c3", 32'h00A200B0, 4'b0101, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("bub.c4", 32'hA300B100, 4'b1010, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("bub.c5", 32'h00B20000, 4'b0100, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("bub.c6", 32'hB3000000, 4'b1000, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("bub.c7", 32'h0, 4'b0000, 1, 1, 0, S_IDLE);
        tick();

        // in_valid held high through FLUSH; next accept lands in the done cycle.
        drive(1'b1, 1'b1, 32'hD3D2D1D0);
        chk_cycle("hold.c0", 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
        tick();
        drive(1'b1, 1'b0, 32'hE3E2E1E0);
        chk_cycle("hold.c1", 32'h000000D0, 4'b0001, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("hold.c2", 32'h0000D100, 4'b0010, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("hold.c3", 32'h00D20000, 4'b0100, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("hold.c4", 32'hD3000000, 4'b1000, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("hold.c5", 32'h0, 4'b0000, 1, 1, 0, S_IDLE);
        tick();
        drive(1'b1, 1'b1, 32'hF3F2F1F0);
        chk_cycle("hold.c6", 32'h000000E0, 4'b0001, 1, 0, 1, S_STREAM);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_cycle("hold.c7", 32'h0000E1F0, 4'b0011, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("hold.c8", 32'h00E2F100, 4'b0110, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("hold.c9", 32'hE3F20000, 4'b1100, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("hold.c10", 32'hF3000000, 4'b1000, 0, 0, 1, S_FLUSH);
        tick();
        chk_cycle("hold.c11", 32'h0, 4'b0000, 1, 1, 0, S_IDLE);
        tick();

        // Reset in the middle of a stream discards skewed data and the flush.
        drive(1'b1, 1'b0, 32'hA3A2A1A0);
        chk_cycle("mrst.c0", 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
        tick();
        drive(1'b1, 1'b0, 32'hB3B2B1B0);
        chk_cycle("mrst.c1", 32'h000000A0, 4'b0001, 1, 0, 1, S_STREAM);
        tick();
        drive(1'b1, 1'b0, 32'hC3C2C1C0);
        rst = 1'b1;
        chk_cycle("mrst.c2", 32'h0000A1B0, 4'b0011, 1, 0, 1, S_STREAM);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        for (int i = 3; i < 9; i++) begin
            chk_cycle($sformatf("mrst.c%0d", i), 32'h0, 4'b0000, 1, 0, 0, S_IDLE);
            tick();
        end

        // A fresh tile after the mid-stream reset.
        run_abc("after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
